// File: rtl/tff_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tff_ctrl_pkg
// Description : Shared types and default constants for the TFF toggle
//               sequencer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        COOL  = 2'd2
    } state_e;

    localparam int N_CH_DEF        = 3;
    localparam int DB_CYCLES_DEF   = 4;
    localparam int STEP_CYCLES_DEF = 16;
    localparam int LED_W           = 4;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Single-channel two-flop synchroniser, debounce counter and
//               one-cycle rising-edge pulse on the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import tff_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    localparam int             CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The edge pulse is registered alongside the level so it aligns with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/tff_toggle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tff_toggle_sequencer
// Description : Debounced button / auto-step requests, round-robin arbitrated
//               into one-hot toggle strobes for a TFF bank, with shadow state.
//               Define TFF_ISSUE_CNT_EN to add the issue_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_toggle_sequencer
    import tff_ctrl_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  btn_in,
    input  logic             auto_en,
    output logic [N_CH-1:0]  tff_t,
    output logic [N_CH-1:0]  tff_q,
    output logic             busy,
    output logic             drop,
`ifdef TFF_ISSUE_CNT_EN
    output logic [7:0]       issue_cnt,
`endif
    output logic [LED_W-1:0] led
);

    localparam int PW = $clog2(N_CH);
    localparam int TW = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0] STEP_MAX = TW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(N_CH - 1);

    state_e          state_q, state_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] tff_t_q, tff_t_d;
    logic [N_CH-1:0] tffq_q, tffq_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   aptr_q, aptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            drop_q, drop_d;

    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] auto_req;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] grant_oh;
    logic [PW-1:0]   grant_idx;
    logic            grant_vld;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn_in[g]),
            .rise_o (btn_rise[g])
        );
    end

    always_comb begin
        timer_d  = '0;
        aptr_d   = aptr_q;
        auto_req = '0;
        if (auto_en) begin
            if (timer_q == STEP_MAX) begin
                auto_req = N_CH'(1) << aptr_q;
                aptr_d   = (aptr_q == PTR_MAX) ? '0 : aptr_q + 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = rr_q;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!grant_vld && pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(idx);
            end
        end
        grant_oh = N_CH'(1) << grant_idx;
    end

    always_comb begin
        state_d = state_q;
        tff_t_d = '0;
        clr     = '0;
        rr_d    = rr_q;
        tffq_d  = tffq_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = ISSUE;
                    tff_t_d = grant_oh;
                    clr     = grant_oh;
                    rr_d    = grant_idx;
                    tffq_d  = tffq_q ^ grant_oh;
                end
            end
            ISSUE:   state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle re-request of the granted channel is re-queued, not dropped.
    always_comb begin
        req       = btn_rise | auto_req;
        pending_d = (pending_q & ~clr) | req;
        drop_d    = drop_q | (|((req & pending_q & ~clr) | (btn_rise & auto_req)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            tff_t_q   <= '0;
            tffq_q    <= '0;
            rr_q      <= PTR_MAX;
            aptr_q    <= '0;
            timer_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tff_t_q   <= tff_t_d;
            tffq_q    <= tffq_d;
            rr_q      <= rr_d;
            aptr_q    <= aptr_d;
            timer_q   <= timer_d;
            drop_q    <= drop_d;
        end
    end

`ifdef TFF_ISSUE_CNT_EN
    logic [7:0] issue_cnt_q;
    logic       issue_go;
    assign issue_go = (state_q == IDLE) && grant_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
        end else if (issue_go) begin
            issue_cnt_q <= issue_cnt_q + 8'd1;
        end
    end

    assign issue_cnt = issue_cnt_q;
`endif

    assign tff_t = tff_t_q;
    assign tff_q = tffq_q;
    assign drop  = drop_q;
    assign busy  = (state_q != IDLE) || (|pending_q);

    assign led[LED_W-1] = busy;
    for (genvar g = 0; g < LED_W - 1; g++) begin : g_led
        if (g < N_CH) begin : g_bit
            assign led[g] = tffq_q[g];
        end else begin : g_zero
            assign led[g] = 1'b0;
        end
    end

endmodule
`default_nettype wire
